// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// fixed window of iCLK_50 cycles and publishes the count with a one-cycle strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 27,
  parameter int GATE_W      = $clog2(GATE_CYCLES)
) (
  input  logic             iCLK_50,
  input  logic             iRST_n,
  input  logic             iSIG,
  input  logic             iEN,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oVALID,
  output logic             oOVF,
  output logic             oBUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic              sync1_reg;
  logic              sync2_reg;
  logic              hist_reg;
  logic              edge_pulse_reg;
  logic [1:0]        prime_reg;

  state_t            state_reg;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic              sat_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              valid_reg;
  logic              ovf_reg;
  logic              busy_reg;

  logic              sat_hit;
  logic              last_cycle;
  logic [CNT_W-1:0]  edge_cnt_next;

  // Synchronizer, history flop and registered edge pulse. The prime counter
  // suppresses the pulse until the synchronizer has flushed its reset zeros,
  // so an input already high at reset release never looks like a rising edge.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      hist_reg       <= 1'b0;
      edge_pulse_reg <= 1'b0;
      prime_reg      <= 2'd0;
    end else begin
      sync1_reg      <= iSIG;
      sync2_reg      <= sync1_reg;
      hist_reg       <= sync2_reg;
      edge_pulse_reg <= sync2_reg & ~hist_reg & (prime_reg == 2'd3);
      if (prime_reg != 2'd3) begin
        prime_reg <= prime_reg + 2'd1;
      end
    end
  end

  always_comb begin
    sat_hit       = edge_pulse_reg & (edge_cnt_reg == CNT_MAX);
    last_cycle    = (gate_cnt_reg == GATE_LAST);
    edge_cnt_next = sat_hit ? edge_cnt_reg : edge_cnt_reg + CNT_W'(edge_pulse_reg);
  end

  // A pulse arriving in the final window cycle is folded into the published
  // count via edge_cnt_next, so it can never leak into the following window.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_reg    <= IDLE;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      sat_reg      <= 1'b0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          gate_cnt_reg <= '0;
          edge_cnt_reg <= '0;
          sat_reg      <= 1'b0;
          if (iEN) begin
            state_reg <= GATE;
            busy_reg  <= 1'b1;
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        GATE: begin
          if (last_cycle) begin
            count_reg    <= edge_cnt_next;
            ovf_reg      <= sat_reg | sat_hit;
            valid_reg    <= 1'b1;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            if (iEN) begin
              state_reg <= GATE;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else if (!iEN) begin
            // Abort: window discarded, published results untouched.
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
          end else begin
            gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
            edge_cnt_reg <= edge_cnt_next;
            sat_reg      <= sat_reg | sat_hit;
          end
        end
        default: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          gate_cnt_reg <= '0;
          edge_cnt_reg <= '0;
          sat_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign oCOUNT = count_reg;
  assign oVALID = valid_reg;
  assign oOVF   = ovf_reg;
  assign oBUSY  = busy_reg;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: an 8-bit and a 3-bit instance on a 100-cycle
// gate, fed from a shared square-wave / pattern generator.
module tb_freq_meter;

  localparam int GC   = 100;
  localparam int PLEN = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gen_sig = 1'b0;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;

  logic [7:0] cnt_a;
  logic       val_a, ovf_a, busy_a;
  logic [2:0] cnt_b;
  logic       val_b, ovf_b, busy_b;

  always #10 clk = ~clk;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) dut_a (
    .iCLK_50(clk), .iRST_n(rst_n), .iSIG(gen_sig), .iEN(en_a),
    .oCOUNT(cnt_a), .oVALID(val_a), .oOVF(ovf_a), .oBUSY(busy_a)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(3)) dut_b (
    .iCLK_50(clk), .iRST_n(rst_n), .iSIG(gen_sig), .iEN(en_b),
    .oCOUNT(cnt_b), .oVALID(val_b), .oOVF(ovf_b), .oBUSY(busy_b)
  );

  int   n_checks = 0;
  int   n_errors = 0;

  // Generator: mode 0 holds a level, 1 is a square wave, 2 plays pat[].
  int   gen_mode = 0;
  logic hold_val = 1'b1;
  int   hi_len = 5;
  int   lo_len = 5;
  int   phase_cnt = 1;
  int   pidx = 0;
  logic pat [0:PLEN-1];
  int   win_exp [0:19];
  int   exp_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the strobe cycle; cycles counts clock edges waited.
  task automatic wait_valid(input bit sel_b, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!(sel_b ? val_b : val_a) && cycles < limit);
    check("valid_seen", sel_b ? val_b : val_a, 1);
    if (sel_b)
      $display("window dut_b: count=%0d ovf=%0d after %0d cycles", cnt_b, ovf_b, cycles);
    else
      $display("window dut_a: count=%0d ovf=%0d after %0d cycles", cnt_a, ovf_a, cycles);
  endtask

  // Each 100-entry block: random legal phases, then one rise placed so that its
  // pulse lands on window cycle 99 (odd blocks) or window cycle 0 (even blocks).
  task automatic build_pattern();
    int   pos;
    int   len;
    int   t;
    logic lvl;
    logic prev;
    for (int w = 0; w < 20; w++) win_exp[w] = 0;
    exp_total = 0;
    for (int m = 0; m < 20; m++) begin
      int b = m * 100;
      for (int i = 0; i < 4; i++) pat[b+i] = 1'b0;
      pos = 4;
      lvl = 1'b1;
      while (pos <= 87) begin
        len = int'($urandom_range(2, 6));
        for (int j = 0; j < len && pos <= 87; j++) begin
          pat[b+pos] = lvl;
          pos++;
        end
        lvl = ~lvl;
      end
      pat[b+88] = pat[b+87];
      pat[b+89] = pat[b+87];
      t = (m % 2 == 0) ? 96 : 95;
      for (int i = 90; i < 100; i++) pat[b+i] = (i >= t && i < t + 3);
    end
    prev = 1'b0;
    for (int p = 0; p < PLEN; p++) begin
      if (pat[p] && !prev) begin
        exp_total++;
        win_exp[(p + 4) / 100]++;
      end
      prev = pat[p];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (gen_mode)
        0: gen_sig = hold_val;
        1: begin
          if (phase_cnt <= 1) begin
            gen_sig   = ~gen_sig;
            phase_cnt = gen_sig ? hi_len : lo_len;
          end else begin
            phase_cnt--;
          end
        end
        default: begin
          gen_sig = (pidx < PLEN) ? pat[pidx] : 1'b0;
          pidx++;
        end
      endcase
    end
  end

  initial begin
    int cyc;
    int sum;
    bit seen;

    // Input held high through reset release: no spurious edge.
    en_a = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_count_a", cnt_a, 0);
    check("rst_valid_a", val_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_count_b", cnt_b, 0);
    check("rst_busy_b", busy_b, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(0, 300, cyc);
    check("held_high_w0", cnt_a, 0);
    wait_valid(0, 150, cyc);
    check("held_high_w1", cnt_a, 0);
    check("held_high_ovf", ovf_a, 0);

    // 5 high / 5 low from reset.
    rst_n = 1'b0;
    gen_mode = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(0, 300, cyc);
    check("sq_first_9_or_10", (cnt_a == 8'd9) || (cnt_a == 8'd10), 1);
    for (int w = 1; w <= 3; w++) begin
      wait_valid(0, 150, cyc);
      check("sq_period", cyc, GC);
      check("sq_count", cnt_a, 10);
      check("sq_ovf", ovf_a, 0);
    end

    // Abort at window cycle 50, then re-enable.
    repeat (50) @(posedge clk);
    #1 en_a = 1'b0;
    @(negedge clk);
    check("abort_busy_before", busy_a, 1);
    @(negedge clk);
    check("abort_busy_after", busy_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (val_a) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_count_hold", cnt_a, 10);
    // Latency counted from the edge after which iEN is driven high.
    @(posedge clk);
    #1 en_a = 1'b1;
    wait_valid(0, 200, cyc);
    check("reen_latency", cyc, 101);
    check("reen_count", cnt_a, 10);

    // Asynchronous reset at window cycle 70.
    repeat (70) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_count", cnt_a, 0);
    check("async_rst_valid", val_a, 0);
    check("async_rst_ovf", ovf_a, 0);
    check("async_rst_busy", busy_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(0, 300, cyc);
    wait_valid(0, 150, cyc);
    check("post_rst_count", cnt_a, 10);
    check("post_rst_ovf", ovf_a, 0);

    // 3-bit instance: 2/2 saturates, then 50/50 gives one edge per window.
    en_a = 1'b0;
    hi_len = 2;
    lo_len = 2;
    en_b = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1, 300, cyc);
      check("sat_count", cnt_b, 7);
      check("sat_ovf", ovf_b, 1);
    end
    hi_len = 50;
    lo_len = 50;
    wait_valid(1, 150, cyc);
    for (int w = 0; w < 2; w++) begin
      wait_valid(1, 150, cyc);
      check("slow_count", cnt_b, 1);
      check("slow_ovf", ovf_b, 0);
    end

    // Random legal input with edges on window boundaries.
    en_b = 1'b0;
    hold_val = 1'b0;
    gen_mode = 0;
    en_a = 1'b1;
    build_pattern();
    wait_valid(0, 300, cyc);
    pidx = 0;
    gen_mode = 2;
    sum = 0;
    for (int w = 0; w < 20; w++) begin
      wait_valid(0, 150, cyc);
      check("rand_window", cnt_a, win_exp[w]);
      sum += int'(cnt_a);
    end
    check("rand_sum", sum, exp_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
